reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  Architectural register file that consumes the write-back stage output
//  (RegWrite / Reg2Write / Data2Write) and serves two decode-stage read ports.
//  Write-to-read bypass on same-cycle hazards; X31 (XZR) always reads zero.
//  Per-register pending-write scoreboard: decode reserves a destination,
//  write-back retires it; read of a still-pending source raises stall.
// PARAMETERS
//  DATA_W    64  register width
//  NREGS     32  number of registers (index width 5)
//  ZERO_REG  31  hard-wired zero register index
//  PEND_W    2   pending-count width per register (max 3 in flight)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  RegWrite     in   1       write-back valid
//  Reg2Write    in   5       write-back destination index
//  Data2Write   in   DATA_W  write-back data
//  ReadReg1     in   5       read port 1 index
//  ReadReg2     in   5       read port 2 index
//  ReadData1    out  DATA_W  read port 1 data (combinational)
//  ReadData2    out  DATA_W  read port 2 data (combinational)
//  ReserveEn    in   1       decode issuing an instruction that writes a reg
//  ReserveReg   in   5       destination being reserved
//  Stall        out  1       a read source has an unretired pending write
//  SbError      out  1       sticky: scoreboard overflow/underflow seen
// BEHAVIOUR
//  Reset (async, active-high): all registers = 0, all pending counts = 0,
//   SbError = 0; Stall = 0 and ReadData* = 0 until reset deasserts.
//  Write: at rising clk, if RegWrite && Reg2Write != ZERO_REG, reg <= Data2Write.
//   Writes to ZERO_REG are discarded (no state change, count still retired).
//  Read (combinational, zero latency):
//   - index == ZERO_REG -> 0
//   - else RegWrite && Reg2Write == index -> Data2Write (bypass)
//   - else stored register value.
//  Scoreboard: cnt[r] (PEND_W bits) per register, ZERO_REG never tracked.
//   - ReserveEn only, r = ReserveReg: cnt+1 at clk edge.
//   - RegWrite only, r = Reg2Write: cnt-1 at clk edge.
//   - both on same r in one cycle: cnt unchanged.
//   - both on different regs: each updated independently.
//   - reserve at cnt == 2^PEND_W-1: cnt holds, SbError <= 1.
//   - retire at cnt == 0: cnt holds 0, SbError <= 1 (write still performed).
//   - SbError clears only on reset.
//  Stall (combinational) = OR over ports p in {1,2}: ReadRegp != ZERO_REG and
//   cnt[ReadRegp] != 0, except when cnt == 1 and RegWrite && Reg2Write ==
//   ReadRegp this cycle (bypass delivers final value).
//  Block does not gate ReserveEn with Stall; decode holds ReserveEn low while
//   stalled. Both ports stalling on one reg gives a single Stall.
//  Reset mid-operation: all pending counts lost; Stall drops immediately.
// TESTING
//  1 Reset, read X0..X31 -> all 0, Stall=0, SbError=0.
//  2 Write X5=0x1234 cycle 1; read X5 cycle 2 -> 0x1234; write X31=0xFF
//    then read X31 -> 0.
//  3 Same cycle RegWrite X7=0xAA and ReadReg1=7 -> ReadData1=0xAA before
//    the edge; stored value 0xAA after.
//  4 Reserve X3; next cycle ReadReg2=3 -> Stall=1; RegWrite X3=0x9 that
//    cycle -> Stall=0, ReadData2=0x9; following cycle cnt=0, Stall=0.
//  5 Reserve X4 twice, retire once -> read X4 still stalls; simultaneous
//    reserve+retire X4 keeps cnt=1; fourth reserve from cnt=3 -> SbError=1.
//  6 RegWrite X9 with cnt=0 -> SbError=1, X9 updated; assert reset while
//    cnt[X3]=2 -> Stall=0, SbError=0 asynchronously.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with write-to-read bypass, hard-wired zero register
// and a per-register pending-write scoreboard that raises Stall on unretired sources.
module reg_file_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 31,
    parameter int PEND_W   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [$clog2(NREGS)-1:0] Reg2Write,
    input  logic [DATA_W-1:0]        Data2Write,
    input  logic [$clog2(NREGS)-1:0] ReadReg1,
    input  logic [$clog2(NREGS)-1:0] ReadReg2,
    output logic [DATA_W-1:0]        ReadData1,
    output logic [DATA_W-1:0]        ReadData2,
    input  logic                     ReserveEn,
    input  logic [$clog2(NREGS)-1:0] ReserveReg,
    output logic                     Stall,
    output logic                     SbError
);

    localparam int IDX_W = $clog2(NREGS);
    localparam logic [IDX_W-1:0]  ZR      = IDX_W'(ZERO_REG);
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [PEND_W-1:0] r_cnt  [NREGS];
    logic              r_sbError;

    logic [NREGS-1:0]  w_inc;
    logic [NREGS-1:0]  w_dec;
    logic              w_err;
    logic              w_stall1;
    logic              w_stall2;

    function automatic logic [DATA_W-1:0] readPort(input logic [IDX_W-1:0] idx);
        if (idx == ZR)
            return '0;
        else if (RegWrite && (Reg2Write == idx))
            return Data2Write;
        else
            return r_regs[idx];
    endfunction

    // A source with exactly one pending write retiring this cycle is satisfied by the bypass.
    function automatic logic pendingSource(input logic [IDX_W-1:0] idx);
        if (idx == ZR || r_cnt[idx] == '0)
            return 1'b0;
        else if (r_cnt[idx] == CNT_ONE && RegWrite && (Reg2Write == idx))
            return 1'b0;
        else
            return 1'b1;
    endfunction

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        w_stall1  = 1'b0;
        w_stall2  = 1'b0;
        if (!reset) begin
            ReadData1 = readPort(ReadReg1);
            ReadData2 = readPort(ReadReg2);
            w_stall1  = pendingSource(ReadReg1);
            w_stall2  = pendingSource(ReadReg2);
        end
        Stall   = w_stall1 | w_stall2;
        SbError = r_sbError;
    end

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        w_err = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (r != ZERO_REG) begin
                w_inc[r] = ReserveEn && (ReserveReg == IDX_W'(r));
                w_dec[r] = RegWrite && (Reg2Write == IDX_W'(r));
                if (w_inc[r] && !w_dec[r] && r_cnt[r] == CNT_MAX)
                    w_err = 1'b1;
                if (w_dec[r] && !w_inc[r] && r_cnt[r] == '0)
                    w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
                r_cnt[r]  <= '0;
            end
            r_sbError <= 1'b0;
        end else begin
            if (RegWrite && Reg2Write != ZR)
                r_regs[Reg2Write] <= Data2Write;
            // Saturating counters: overflow and underflow hold the count and flag the error.
            for (int r = 0; r < NREGS; r++) begin
                if (w_inc[r] && !w_dec[r] && r_cnt[r] != CNT_MAX)
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                else if (w_dec[r] && !w_inc[r] && r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
            end
            if (w_err)
                r_sbError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: a behavioural model pushes expected
// outputs to a queue as stimulus is driven; they are popped and compared mid-cycle.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  Reg2Write;
    logic [63:0] Data2Write;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        ReserveEn;
    logic [4:0]  ReserveReg;
    logic        Stall;
    logic        SbError;

    typedef struct {
        string       tag;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t        expQ [$];
    logic [63:0] mRegs [32];
    int          mCnt  [32];
    logic        mErr;
    int          checks   = 0;
    int          failures = 0;

    reg_file_scoreboard dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .Reg2Write(Reg2Write), .Data2Write(Data2Write),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ReserveEn(ReserveEn), .ReserveReg(ReserveReg),
        .Stall(Stall), .SbError(SbError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            mRegs[r] = '0;
            mCnt[r]  = 0;
        end
        mErr = 1'b0;
    endtask

    function automatic logic [63:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd31) return '0;
        if (RegWrite && Reg2Write == idx) return Data2Write;
        return mRegs[idx];
    endfunction

    function automatic logic modelPending(input logic [4:0] idx);
        if (idx == 5'd31 || mCnt[idx] == 0) return 1'b0;
        if (mCnt[idx] == 1 && RegWrite && Reg2Write == idx) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelEdge();
        if (RegWrite && Reg2Write != 5'd31) mRegs[Reg2Write] = Data2Write;
        for (int r = 0; r < 31; r++) begin
            logic inc, dec;
            inc = ReserveEn && ReserveReg == 5'(r);
            dec = RegWrite && Reg2Write == 5'(r);
            if (inc && !dec) begin
                if (mCnt[r] == 3) mErr = 1'b1; else mCnt[r]++;
            end else if (dec && !inc) begin
                if (mCnt[r] == 0) mErr = 1'b1; else mCnt[r]--;
            end
        end
    endtask

    // Drive one cycle of stimulus, queue the model's prediction, compare before the edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [4:0] wreg,
                                 input logic [63:0] wdata, input logic [4:0] r1,
                                 input logic [4:0] r2, input logic res, input logic [4:0] resReg);
        exp_t e, got;
        RegWrite = we; Reg2Write = wreg; Data2Write = wdata;
        ReadReg1 = r1; ReadReg2 = r2; ReserveEn = res; ReserveReg = resReg;
        e.tag   = tag;
        e.rd1   = modelRead(r1);
        e.rd2   = modelRead(r2);
        e.stall = modelPending(r1) | modelPending(r2);
        e.err   = mErr;
        expQ.push_back(e);
        @(negedge clk);
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            got = expQ.pop_front();
            checkOutput({got.tag, "_rd1"},   ReadData1, got.rd1);
            checkOutput({got.tag, "_rd2"},   ReadData2, got.rd2);
            checkOutput({got.tag, "_stall"}, {63'd0, Stall},   {63'd0, got.stall});
            checkOutput({got.tag, "_err"},   {63'd0, SbError}, {63'd0, got.err});
        end
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        RegWrite = 0; Reg2Write = 0; Data2Write = 0; ReadReg1 = 0; ReadReg2 = 0;
        ReserveEn = 0; ReserveReg = 0;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        #2;
        checkOutput("rst_stall", {63'd0, Stall},   64'd0);
        checkOutput("rst_err",   {63'd0, SbError}, 64'd0);
        modelReset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idleInputs();
        modelReset();
        @(posedge clk);
        #1;
        // Bypass must not leak through while reset is held.
        RegWrite = 1; Reg2Write = 5'd1; Data2Write = 64'hFF; ReadReg1 = 5'd1;
        #1;
        checkOutput("rst_bypass", ReadData1, 64'd0);
        idleInputs();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 16; i++)
            applyStimulus("t1_read", 0, 0, 0, 5'(i), 5'(i + 16), 0, 0);

        applyStimulus("t2_wr5",   1, 5'd5,  64'h1234, 0, 0, 0, 0);
        applyStimulus("t2_rd5",   0, 0, 0, 5'd5, 0, 0, 0);
        checkOutput("t2_x5_const", ReadData1, 64'h1234);
        applyStimulus("t2_wr31",  1, 5'd31, 64'hFF, 5'd31, 0, 0, 0);
        applyStimulus("t2_rd31",  0, 0, 0, 5'd31, 5'd31, 0, 0);
        checkOutput("t2_x31_const", ReadData1, 64'd0);

        applyStimulus("t3_bypass", 1, 5'd7, 64'hAA, 5'd7, 0, 0, 0);
        applyStimulus("t3_stored", 0, 0, 0, 5'd7, 5'd7, 0, 0);
        checkOutput("t3_x7_const", ReadData2, 64'hAA);

        applyStimulus("t4_res3",   0, 0, 0, 0, 0, 1, 5'd3);
        applyStimulus("t4_stall",  0, 0, 0, 0, 5'd3, 0, 0);
        applyStimulus("t4_retire", 1, 5'd3, 64'h9, 0, 5'd3, 0, 0);
        applyStimulus("t4_clear",  0, 0, 0, 0, 5'd3, 0, 0);
        checkOutput("t4_stall_const", {63'd0, Stall}, 64'd0);

        applyStimulus("t5_res4a", 0, 0, 0, 0, 0, 1, 5'd4);
        applyStimulus("t5_res4b", 0, 0, 0, 0, 0, 1, 5'd4);
        applyStimulus("t5_ret4",  1, 5'd4, 64'h44, 0, 0, 0, 0);
        applyStimulus("t5_rd4",   0, 0, 0, 5'd4, 0, 0, 0);
        checkOutput("t5_stall_const", {63'd0, Stall}, 64'd1);
        applyStimulus("t5_both",  1, 5'd4, 64'h45, 0, 0, 1, 5'd4);
        applyStimulus("t5_rd4b",  0, 0, 0, 5'd4, 5'd4, 0, 0);
        applyStimulus("t5_res4c", 0, 0, 0, 0, 0, 1, 5'd4);
        applyStimulus("t5_res4d", 0, 0, 0, 0, 0, 1, 5'd4);
        applyStimulus("t5_ovf",   0, 0, 0, 0, 0, 1, 5'd4);
        applyStimulus("t5_errchk", 0, 0, 0, 5'd4, 0, 0, 0);
        checkOutput("t5_err_const", {63'd0, SbError}, 64'd1);

        pulseReset();
        applyStimulus("t6_udf",   1, 5'd9, 64'h99, 0, 0, 0, 0);
        applyStimulus("t6_rd9",   0, 0, 0, 5'd9, 0, 0, 0);
        checkOutput("t6_err_const", {63'd0, SbError}, 64'd1);
        applyStimulus("t6_res3a", 0, 0, 0, 0, 0, 1, 5'd3);
        applyStimulus("t6_res3b", 0, 0, 0, 0, 0, 1, 5'd3);
        ReadReg1 = 5'd3;
        #1;
        checkOutput("t6_pre_stall", {63'd0, Stall}, 64'd1);
        pulseReset();
        idleInputs();

        for (int i = 0; i < 60; i++)
            applyStimulus("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                          {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) == 0),
                          5'($urandom_range(0, 31)));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
